// File: rtl/reg_file_mp.sv
// Multi-port integer register file with registered reads and a busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes and busy clears to reads.
module reg_file_mp #(
  parameter int ADW      = 5,
  parameter int DPW      = 32,
  parameter int NRP      = 2,
  parameter int NWP      = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [NRP-1:0]       rd_en,
  input  logic [NRP*ADW-1:0]   rd_addr,
  output logic [NRP*DPW-1:0]   rd_data,
  output logic [NRP-1:0]       rd_valid,
  output logic [NRP-1:0]       rd_busy,
  input  logic [NWP-1:0]       we,
  input  logic [NWP*ADW-1:0]   wr_addr,
  input  logic [NWP*DPW-1:0]   wr_data,
  input  logic                 bsy_set,
  input  logic [ADW-1:0]       bsy_addr
);

  localparam int DEPTH = 1 << ADW;

  logic [DEPTH-1:0][DPW-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]          busy_q, busy_d, clr_mask;
  logic [NRP-1:0][DPW-1:0]   rd_data_q, rd_data_d;
  logic [NRP-1:0]            rd_busy_q, rd_busy_d;
  logic [NRP-1:0]            rd_valid_q, rd_valid_d;

  logic [NRP-1:0][ADW-1:0]   ra;
  logic [NWP-1:0][ADW-1:0]   wa;
  logic [NWP-1:0][DPW-1:0]   wd;

  assign ra = rd_addr;
  assign wa = wr_addr;
  assign wd = wr_data;

  function automatic logic is_zero(input logic [ADW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Later write ports overwrite earlier ones, so the highest-index port wins.
  always_comb begin : write_path
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mem_d    = mem_q;
    clr_mask = '0;
    for (int w = 0; w < NWP; w++) begin
      if (we[w] && !is_zero(wa[w])) begin
        mem_d[wa[w]]    = wd[w];
        clr_mask[wa[w]] = 1'b1;
      end
    end
    busy_d = busy_q & ~clr_mask;
    // A set after the clears lets a newly issued producer win over a retiring one.
    if (bsy_set && !is_zero(bsy_addr)) begin
      busy_d[bsy_addr] = 1'b1;
    end
  end

  always_comb begin : read_path
    rd_data_d  = rd_data_q;
    rd_busy_d  = rd_busy_q;
    rd_valid_d = rd_en;
    for (int p = 0; p < NRP; p++) begin
      if (rd_en[p]) begin
`ifdef REGFILE_BYPASS_EN
        rd_data_d[p] = mem_d[ra[p]];
        rd_busy_d[p] = busy_q[ra[p]] & ~clr_mask[ra[p]];
`else
        rd_data_d[p] = mem_q[ra[p]];
        rd_busy_d[p] = busy_q[ra[p]];
`endif
        if (is_zero(ra[p])) begin
          rd_data_d[p] = '0;
          rd_busy_d[p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      // NOTE: the storage array is reset like any other state so no entry ever reads X.
      mem_q      <= '0;
      busy_q     <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_busy  = rd_busy_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the RISC-V core, with configurable read/write port counts and registered reads. Writes and reads proceed in the same cycle without blocking each other. Register 0 is optionally hardwired to zero. A per-register busy scoreboard lets the decode stage detect read-after-write hazards against in-flight writebacks.

## Interface
- ADW, 5, address width; depth = 2**ADW entries
- DPW, 32, data width
- NRP, 2, number of read ports (1..4)
- NWP, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = entry 0 reads as zero, ignores writes, never busy

- clk  in  1  clock, all state updates on rising edge
- arst_n  in  1  reset, asynchronous, active-low
- rd_en  in  NRP  per-port read request
- rd_addr  in  NRP*ADW  read addresses, port p at [p*ADW +: ADW]
- rd_data  out  NRP*DPW  registered read data, port p at [p*DPW +: DPW]
- rd_valid  out  NRP  high one cycle after an accepted rd_en
- rd_busy  out  NRP  registered busy flag of the address read
- we  in  NWP  per-port write enable
- wr_addr  in  NWP*ADW  write addresses
- wr_data  in  NWP*DPW  write data
- bsy_set  in  1  mark bsy_addr busy (instruction issued with destination bsy_addr)
- bsy_addr  in  ADW  scoreboard set address

## Operation
- Storage: 2**ADW x DPW flops. All entries are cleared on reset; no entry is left uninitialised.
- Write: on a clock edge with we[w]=1, entry wr_addr[w] <= wr_data[w].
  - If both write ports target the same address, the highest-index port wins.
  - When ZERO_REG=1, writes to address 0 are dropped.
- Scoreboard: one busy bit per entry.
  - bsy_set sets busy[bsy_addr].
  - Any accepted write clears busy[wr_addr].
  - If a set and a clear hit the same address in the same cycle, the set wins (a new producer has issued).
  - Address 0 is never busy when ZERO_REG=1.
- Read: on a clock edge with rd_en[p]=1, the port captures the entry into rd_data[p] and the busy bit into rd_busy[p], and drives rd_valid[p]=1 for the next cycle.
  - With rd_en[p]=0: rd_data[p] and rd_busy[p] hold their values and rd_valid[p]=0.
- Reads are never stalled by writes. Read ports are fully independent, and any number may read the same address.
- Address 0 with ZERO_REG=1 always returns data 0 and busy 0.

## Timing
- Read latency is 1 cycle: address presented at edge N, data valid after edge N+1.
- Writes are visible to reads sampled at the following edge. Same-cycle visibility is set by the configuration below.
- Scoreboard same-cycle semantics:
  - A bsy_set in the same cycle as a read is not visible until the next read.
  - A clear in the same cycle as a read follows the bypass rule.
- Reset values: rd_data=0, rd_valid=0, rd_busy=0, all entries 0, all busy bits 0.
- Reset asserted mid-operation clears all state immediately. Any reads in flight are lost and rd_valid drops asynchronously.
- Reset deassertion is synchronous to clk through the system reset synchroniser; the block adds none.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: a read sampling an address that is written in the same cycle returns the new write data (highest-index write port if both match) and rd_busy reflects the clear.
- Undefined: that read returns the old entry contents and the pre-clear busy bit. The new value is visible from the next read.
- In both builds, writes to address 0 with ZERO_REG=1 are never bypassed.

## Test plan
- Reset, then read all 32 addresses on both ports -> every rd_data=0, rd_busy=0, rd_valid high exactly 1 cycle after each rd_en.
- Write 0xDEADBEEF to x5, then read x5 on port 0 and x0 on port 1 in the next cycle -> port 0 returns 0xDEADBEEF, port 1 returns 0. Separately, write 0x1234 to x0, then read x0 -> returns 0.
- Same-cycle write of 0xA5A5A5A5 to x7 and read of x7, where x7 was previously 0x11 -> returns 0xA5A5A5A5 with REGFILE_BYPASS_EN defined, 0x11 without. A second read returns 0xA5A5A5A5 in both builds.
- NWP=2, both ports write x9 (0x1 on port 0, 0x2 on port 1) -> subsequent read returns 0x2.
- Scoreboard:
  - bsy_set x3, then read x3 -> rd_busy=1.
  - Write x3, then read -> rd_busy=0.
  - bsy_set x3 and a write to x3 in the same cycle, then read -> rd_busy=1.
- Assert arst_n low while rd_en is active and x4=0x55 -> rd_valid and rd_data drop to 0 immediately. After release, reading x4 returns 0.
